pipelined_op_decoder: RTL and testbench

- Registered, handshaked successor to the combinational opcode decoder; sits between the IF/ID boundary and the execute stage.
- Decodes a full 32-bit MIPS instruction into the control bundle, register indices, extended immediate and destination register.
- Adds jr support, an illegal-instruction flag, a parametrised load-use interlock, flush, and a saturating stall counter.

---
 rtl/decoder_pkg.sv | 67 ++++++
 rtl/op_decode_comb.sv | 99 +++++++++
 rtl/pipelined_op_decoder.sv | 140 ++++++++++++++
 tb/tb_pipelined_op_decoder.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared definitions for the pipelined MIPS decode stage.
// Contents:
//   - opcode and funct encodings
//   - the control-bundle width, its bit positions and its packed struct
package decoder_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_COP0  = 6'h10;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam int CTRL_W          = 13;
  localparam int CTRL_MEM_READ   = 12;
  localparam int CTRL_MEM_WRITE  = 11;
  localparam int CTRL_ALU_SRC    = 10;
  localparam int CTRL_JUMP       = 9;
  localparam int CTRL_JUMP_REG   = 8;
  localparam int CTRL_MEM_TO_REG = 7;
  localparam int CTRL_BRANCH     = 6;
  localparam int CTRL_BNE_BEQ    = 5;
  localparam int CTRL_REG_WRITE  = 4;
  localparam int CTRL_IS_JAL     = 3;
  localparam int CTRL_ZERO_EXT   = 2;
  localparam int CTRL_READ_RS    = 1;
  localparam int CTRL_READ_RT    = 0;

  // Field order matches the bit positions above (MSB first).
  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic alu_src;
    logic jump;
    logic jump_reg;
    logic mem_to_reg;
    logic branch;
    logic bne_beq;
    logic reg_write;
    logic is_jal;
    logic zero_ext;
    logic read_rs;
    logic read_rt;
  } ctrl_t;

endpackage

// File: rtl/op_decode_comb.sv
// Pure combinational decode table: instruction word -> control bundle,
// illegal flag, destination register and extended immediate.
// Ports:
//   instr_i   32-bit instruction
//   ctrl_o    control bundle (all zero when illegal)
//   illegal_o op/funct not in the table
//   dst_o     31 for jal, rd for R-type, else rt; 0 when nothing is written
//   imm_o     instr[15:0] zero- or sign-extended
module op_decode_comb
  import decoder_pkg::*;
(
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o,
  output logic        illegal_o,
  output logic [4:0]  dst_o,
  output logic [31:0] imm_o
);

  logic [5:0] op, fn;
  logic       reg_dst;

  assign op = instr_i[31:26];
  assign fn = instr_i[5:0];

  always_comb begin
    ctrl_o    = '0;
    illegal_o = 1'b0;
    reg_dst   = 1'b0;
    case (op)
      OP_RTYPE: begin
        reg_dst = 1'b1;
        case (fn)
          FN_ADD, FN_ADDU, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT, FN_SLTU: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.read_rs   = 1'b1;
            ctrl_o.read_rt   = 1'b1;
          end
          FN_SLL, FN_SRL, FN_SRA: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.read_rt   = 1'b1;
          end
          FN_JR: begin
            ctrl_o.jump     = 1'b1;
            ctrl_o.jump_reg = 1'b1;
            ctrl_o.read_rs  = 1'b1;
          end
          default: illegal_o = 1'b1;
        endcase
      end
      OP_J:   ctrl_o.jump = 1'b1;
      OP_JAL: begin
        ctrl_o.jump      = 1'b1;
        ctrl_o.is_jal    = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl_o.branch  = 1'b1;
        ctrl_o.bne_beq = (op == OP_BNE);
        ctrl_o.read_rs = 1'b1;
        ctrl_o.read_rt = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.read_rs   = 1'b1;
        ctrl_o.zero_ext  = (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
      end
      OP_COP0: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.read_rt   = 1'b1;
      end
      OP_LW: begin
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.read_rs    = 1'b1;
      end
      OP_SW: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.read_rs   = 1'b1;
        ctrl_o.read_rt   = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
  end

  always_comb begin
    if (ctrl_o.is_jal)         dst_o = 5'd31;
    else if (!ctrl_o.reg_write) dst_o = 5'd0;
    else if (reg_dst)          dst_o = instr_i[15:11];
    else                       dst_o = instr_i[20:16];
  end

  assign imm_o = ctrl_o.zero_ext ? {16'h0000, instr_i[15:0]}
                                 : {{16{instr_i[15]}}, instr_i[15:0]};

endmodule

// File: rtl/pipelined_op_decoder.sv
// Registered decode stage between IF/ID and execute, valid/ready on both
// sides, with load-use interlock, flush and a saturating stall counter.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         instruction handshake (in_instr, in_pc)
//   flush                     kill the output stage, refuse input this cycle
//   out_valid/out_ready       decoded bundle handshake
//   out_ctrl/rs/rt/dst/imm/pc decoded bundle, out_illegal flags bad encodings
//   stall_cnt                 cycles an offered instruction was held by a hazard
module pipelined_op_decoder
  import decoder_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int LOAD_SHADOW = 1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  input  logic [PC_W-1:0]        in_pc,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [4:0]             out_rs,
  output logic [4:0]             out_rt,
  output logic [4:0]             out_dst,
  output logic [31:0]            out_imm,
  output logic [PC_W-1:0]        out_pc,
  output logic                   out_illegal,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  ctrl_t       dec_ctrl;
  logic        dec_ill;
  logic [4:0]  dec_dst, dec_rs, dec_rt;
  logic [31:0] dec_imm;

  op_decode_comb u_dec (
    .instr_i   (in_instr),
    .ctrl_o    (dec_ctrl),
    .illegal_o (dec_ill),
    .dst_o     (dec_dst),
    .imm_o     (dec_imm)
  );

  assign dec_rs = in_instr[25:21];
  assign dec_rt = in_instr[20:16];

  logic                        out_valid_q, out_valid_d;
  ctrl_t                       ctrl_q;
  logic [4:0]                  rs_q, rt_q, dst_q;
  logic [31:0]                 imm_q;
  logic [PC_W-1:0]             pc_q;
  logic                        ill_q;
  logic [LOAD_SHADOW-1:0]      shadow_v_q, shadow_v_d;
  logic [LOAD_SHADOW-1:0][4:0] shadow_r_q, shadow_r_d;
  logic [STALL_CNT_W-1:0]      stall_q, stall_d;

  logic rs_hit, rt_hit, hazard, load_en, accept, out_hs, push;

  // A register is busy if the output stage holds a lw writing it, or a
  // recently issued lw to it is still in the shadow window.
  always_comb begin
    rs_hit = out_valid_q & ctrl_q.mem_read & (dst_q == dec_rs);
    rt_hit = out_valid_q & ctrl_q.mem_read & (dst_q == dec_rt);
    for (int i = 0; i < LOAD_SHADOW; i++) begin
      rs_hit = rs_hit | (shadow_v_q[i] & (shadow_r_q[i] == dec_rs));
      rt_hit = rt_hit | (shadow_v_q[i] & (shadow_r_q[i] == dec_rt));
    end
    if (dec_rs == 5'd0) rs_hit = 1'b0;
    if (dec_rt == 5'd0) rt_hit = 1'b0;
  end

  assign hazard   = in_valid & ((dec_ctrl.read_rs & rs_hit) | (dec_ctrl.read_rt & rt_hit));
  assign load_en  = !out_valid_q | out_ready;
  assign in_ready = !flush & !hazard & load_en;
  assign accept   = in_valid & in_ready;
  // A bundle killed by flush never issues, so it cannot shadow anything.
  assign out_hs   = out_valid_q & out_ready & !flush;
  assign push     = out_hs & ctrl_q.mem_read & (dst_q != 5'd0);

  always_comb begin
    out_valid_d   = flush ? 1'b0 : (load_en ? accept : out_valid_q);
    shadow_v_d    = '0;
    shadow_r_d    = '0;
    shadow_v_d[0] = push;
    shadow_r_d[0] = dst_q;
    for (int i = 1; i < LOAD_SHADOW; i++) begin
      shadow_v_d[i] = shadow_v_q[i-1];
      shadow_r_d[i] = shadow_r_q[i-1];
    end
    stall_d = stall_q;
    if (in_valid & hazard & !flush & ~&stall_q)
      stall_d = stall_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      dst_q       <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      ill_q       <= 1'b0;
      shadow_v_q  <= '0;
      shadow_r_q  <= '0;
      stall_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      if (accept) begin
        ctrl_q <= dec_ctrl;
        rs_q   <= dec_rs;
        rt_q   <= dec_rt;
        dst_q  <= dec_dst;
        imm_q  <= dec_imm;
        pc_q   <= in_pc;
        ill_q  <= dec_ill;
      end
      shadow_v_q <= shadow_v_d;
      shadow_r_q <= shadow_r_d;
      stall_q    <= stall_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_ctrl    = ctrl_q;
  assign out_rs      = rs_q;
  assign out_rt      = rt_q;
  assign out_dst     = dst_q;
  assign out_imm     = imm_q;
  assign out_pc      = pc_q;
  assign out_illegal = ill_q;
  assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_pipelined_op_decoder.sv
module tb_pipelined_op_decoder;

  localparam int LS = 1;

  // Control-bit masks, MemRead at bit 12 down to ReadRt at bit 0.
  localparam int MR = 4096, MW = 2048, ALUS = 1024, JMP = 512, JR = 256, MTR = 128;
  localparam int BR = 64, BNE = 32, RW = 16, JAL = 8, ZE = 4, RS = 2, RT = 1;

  logic        clk, rst, in_valid, in_ready, flush, out_valid, out_ready, out_illegal;
  logic [31:0] in_instr, in_pc, out_imm, out_pc;
  logic [12:0] out_ctrl;
  logic [4:0]  out_rs, out_rt, out_dst;
  logic [15:0] stall_cnt;

  pipelined_op_decoder #(.PC_W(32), .LOAD_SHADOW(LS), .STALL_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_rs(out_rs), .out_rt(out_rt), .out_dst(out_dst), .out_imm(out_imm),
    .out_pc(out_pc), .out_illegal(out_illegal), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  typedef struct {
    logic [12:0] c;
    logic        ill;
    logic [4:0]  dst;
    logic [31:0] imm;
  } ref_t;

  typedef struct {
    int         cyc;
    logic [4:0] r;
  } ld_t;

  // Reference model state: output stage contents and issued loads by cycle.
  ld_t         loads[$];
  bit          m_ov;
  ref_t        m_d;
  logic [4:0]  m_rs, m_rt;
  logic [31:0] m_pc;
  int unsigned m_stall;
  int          cyc;
  bit          last_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ref_t ref_decode(input logic [31:0] w);
    ref_t r;
    int c;
    c = 0;
    r.ill = 1'b0;
    case (w[31:26])
      6'h00: case (w[5:0])
        6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h2B: c = RW | RS | RT;
        6'h00, 6'h02, 6'h03: c = RW | RT;
        6'h08: c = JMP | JR | RS;
        default: r.ill = 1'b1;
      endcase
      6'h02: c = JMP;
      6'h03: c = JMP | JAL | RW;
      6'h04: c = BR | RS | RT;
      6'h05: c = BR | BNE | RS | RT;
      6'h08, 6'h09, 6'h0A: c = ALUS | RW | RS;
      6'h0C, 6'h0D, 6'h0E: c = ALUS | RW | RS | ZE;
      6'h10: c = RW | RT;
      6'h23: c = MR | MTR | ALUS | RW | RS;
      6'h2B: c = MW | ALUS | RS | RT;
      default: r.ill = 1'b1;
    endcase
    r.c = c[12:0];
    if ((c & JAL) != 0)      r.dst = 5'd31;
    else if ((c & RW) == 0)  r.dst = 5'd0;
    else if (w[31:26] == 0)  r.dst = w[15:11];
    else                     r.dst = w[20:16];
    r.imm = ((c & ZE) != 0) ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
    return r;
  endfunction

  function automatic bit blocked(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    if (m_ov && m_d.c[12] && m_d.dst == r) return 1'b1;
    foreach (loads[i])
      if (cyc - loads[i].cyc >= 1 && cyc - loads[i].cyc <= LS && loads[i].r == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive(input bit v, input logic [31:0] w, input logic [31:0] pc);
    in_valid = v;
    in_instr = w;
    in_pc    = pc;
  endtask

  // One clock: compare DUT against the model mid-cycle, advance the model,
  // then return just after the rising edge.
  task automatic tick();
    ref_t di;
    bit   hz, rdy;
    @(negedge clk);
    di  = ref_decode(in_instr);
    hz  = in_valid && ((di.c[1] && blocked(in_instr[25:21])) || (di.c[0] && blocked(in_instr[20:16])));
    rdy = !flush && !hz && (!m_ov || out_ready);
    chk("in_ready", in_ready, rdy);
    chk("out_valid", out_valid, m_ov);
    chk("stall_cnt", stall_cnt, m_stall);
    if (m_ov) begin
      chk("out_ctrl", out_ctrl, m_d.c);
      chk("out_illegal", out_illegal, m_d.ill);
      chk("out_dst", out_dst, m_d.dst);
      chk("out_imm", out_imm, m_d.imm);
      chk("out_rs", out_rs, m_rs);
      chk("out_rt", out_rt, m_rt);
      chk("out_pc", out_pc, m_pc);
    end
    last_acc = 1'b0;
    if (rst) begin
      m_ov = 1'b0;
      m_stall = 0;
      loads.delete();
    end else begin
      if (m_ov && out_ready && !flush && m_d.c[12] && m_d.dst != 0) loads.push_back('{cyc, m_d.dst});
      if (in_valid && hz && !flush && m_stall != 65535) m_stall++;
      last_acc = in_valid && rdy;
      if (flush) m_ov = 1'b0;
      else if (!m_ov || out_ready) begin
        m_ov = last_acc;
        if (last_acc) begin
          m_d  = di;
          m_rs = in_instr[25:21];
          m_rt = in_instr[20:16];
          m_pc = in_pc;
        end
      end
    end
    cyc++;
    while (loads.size() > 0 && cyc - loads[0].cyc > LS) void'(loads.pop_front());
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    int          ops[19] = '{0, 0, 0, 2, 3, 4, 5, 8, 9, 10, 12, 13, 14, 16, 35, 35, 43, 63, 1};
    int          fns[14] = '{'h20, 'h21, 'h22, 'h24, 'h25, 'h27, 'h2A, 'h2B, 0, 2, 3, 8, 1, 'h3F};
    logic [31:0] w;
    int          op, fn;
    op = ops[$urandom_range(0, 18)];
    fn = fns[$urandom_range(0, 13)];
    w = $urandom;
    w[31:26] = op[5:0];
    w[25:21] = 5'($urandom_range(0, 3));
    w[20:16] = 5'($urandom_range(0, 3));
    w[15:11] = 5'($urandom_range(0, 3));
    if (op == 0) w[5:0] = fn[5:0];
    return w;
  endfunction

  initial begin
    int hold;
    cyc = 0;
    m_ov = 1'b0;
    m_stall = 0;
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_ctrl", out_ctrl, 13'h0);
    chk("rst_out_dst", out_dst, 5'd0);
    chk("rst_out_imm", out_imm, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_stall", stall_cnt, 16'h0);
    rst = 1'b0;

    // Load-use: lw $8,0($9) then add $10,$8,$11.
    drive(1, 32'h8D280000, 32'h100);
    tick();
    chk("lw_acc", last_acc, 1'b1);
    chk("lw_ctrl", out_ctrl, 13'h1492);
    chk("lw_dst", out_dst, 5'd8);
    drive(1, 32'h010B5020, 32'h104);
    hold = 0;
    tick();
    while (!last_acc && hold < 8) begin
      hold++;
      tick();
    end
    chk("add_hold", hold, 2);
    chk("add_stall", stall_cnt, 16'd2);
    chk("add_ctrl", out_ctrl, 13'h0013);
    chk("add_dst", out_dst, 5'd10);

    // jal / jr.
    drive(1, 32'h0C000010, 32'h200);
    tick();
    chk("jal_ctrl", out_ctrl, 13'h0218);
    chk("jal_dst", out_dst, 5'd31);
    drive(1, 32'h03E00008, 32'h204);
    tick();
    chk("jr_ctrl", out_ctrl, 13'h0302);
    chk("jr_dst", out_dst, 5'd0);

    // Immediate extension.
    drive(1, 32'h34048001, 32'h208);
    tick();
    chk("ori_imm", out_imm, 32'h00008001);
    drive(1, 32'h2004FFFF, 32'h20C);
    tick();
    chk("addi_imm", out_imm, 32'hFFFFFFFF);

    // Backpressure.
    drive(0, 32'h0, 32'h0);
    tick();
    out_ready = 1'b0;
    drive(1, 32'h00851020, 32'h300);
    tick();
    drive(1, 32'h00A62022, 32'h304);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_pc_hold", out_pc, 32'h300);
      chk("bp_no_acc", last_acc, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_acc", last_acc, 1'b1);
    chk("bp_pc_next", out_pc, 32'h304);

    // Flush with a valid output and an offered instruction.
    drive(1, 32'h00C72824, 32'h308);
    flush = 1'b1;
    tick();
    chk("flush_no_acc", last_acc, 1'b0);
    chk("flush_out_valid", out_valid, 1'b0);
    flush = 1'b0;
    tick();
    chk("flush_retry_acc", last_acc, 1'b1);
    chk("flush_retry_pc", out_pc, 32'h308);

    // Illegal encodings.
    drive(1, 32'hFC000000, 32'h400);
    tick();
    chk("ill_op", out_illegal, 1'b1);
    chk("ill_op_ctrl", out_ctrl, 13'h0);
    chk("ill_op_dst", out_dst, 5'd0);
    drive(1, 32'h00221801, 32'h404);
    tick();
    chk("ill_fn", out_illegal, 1'b1);

    // Reset in the middle of a load-use stall.
    drive(1, 32'h8D280000, 32'h500);
    tick();
    drive(1, 32'h010B5020, 32'h504);
    tick();
    chk("mid_stall_held", last_acc, 1'b0);
    rst = 1'b1;
    tick();
    chk("rst_mid_valid", out_valid, 1'b0);
    chk("rst_mid_stall", stall_cnt, 16'h0);
    rst = 1'b0;
    tick();
    chk("rst_shadow_clear", last_acc, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 4) != 0, rand_instr(), $urandom);
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 16) == 0;
      rst       = ($urandom % 200) == 0;
      tick();
    end
    rst = 1'b0;
    flush = 1'b0;
    drive(0, 32'h0, 32'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
